// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_param_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int CNT_W      = 5
);
    logic [FIFO_WIDTH-1:0] d_in;
    logic                  wr_req;
    logic                  rd_req;
    logic [FIFO_WIDTH-1:0] d_out;
    logic                  wr_ack;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic [CNT_W-1:0]      count;

    modport master (
        output d_in, wr_req, rd_req,
        input  d_out, wr_ack, rd_valid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );

    modport slave (
        input  d_in, wr_req, rd_req,
        output d_out, wr_ack, rd_valid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with an arbitrary depth, an occupancy count,
// programmable almost-full/almost-empty thresholds, overflow/underflow pulses,
// and either a registered read path or a first-word-fall-through read path.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_param_if.slave   bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_r;
    logic [PTR_W-1:0]      rptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic                  wr_ack_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  wr_ok_s;
    logic                  rd_ok_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [PTR_W-1:0]      wptr_inc_s;
    logic [PTR_W-1:0]      rptr_inc_s;

    // Judge both requests on the registered flags and derive next occupancy and pointer increments.
    always_comb begin
        wr_ok_s     = 1'b0;
        rd_ok_s     = 1'b0;
        count_nxt_s = count_r;
        wptr_inc_s  = wptr_r;
        rptr_inc_s  = rptr_r;

        if (bus.wr_req && !full_r) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end

        if (bus.rd_req && !empty_r) begin
            rd_ok_s = 1'b1;
        end else begin
            rd_ok_s = 1'b0;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase

        // Depth need not be a power of two, so wrap by explicit compare.
        if (wptr_r == PTR_W'(FIFO_DEPTH - 1)) begin
            wptr_inc_s = '0;
        end else begin
            wptr_inc_s = wptr_r + PTR_W'(1);
        end

        if (rptr_r == PTR_W'(FIFO_DEPTH - 1)) begin
            rptr_inc_s = '0;
        end else begin
            rptr_inc_s = rptr_r + PTR_W'(1);
        end
    end

    // Pointers, occupancy, status flags and single-cycle handshake/error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r         <= '0;
            rptr_r         <= '0;
            count_r        <= '0;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            wr_ack_r       <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wptr_r <= wptr_inc_s;
            end
            if (rd_ok_s) begin
                rptr_r <= rptr_inc_s;
            end
            count_r        <= count_nxt_s;
            full_r         <= (count_nxt_s == CNT_W'(FIFO_DEPTH));
            empty_r        <= (count_nxt_s == CNT_W'(0));
            almost_full_r  <= (count_nxt_s >= CNT_W'(AF_LEVEL));
            almost_empty_r <= (count_nxt_s <= CNT_W'(AE_LEVEL));
            wr_ack_r       <= wr_ok_s;
            overflow_r     <= bus.wr_req && full_r;
            underflow_r    <= bus.rd_req && empty_r;
        end
    end

    // Storage array; contents survive reset, only the pointers are flushed.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_s) begin
            mem_r[wptr_r] <= bus.d_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; valid whenever something is stored.
            assign bus.d_out    = mem_r[rptr_r];
            assign bus.rd_valid = !empty_r;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] d_out_r;
            logic                  rd_valid_r;

            // Registered read: data and a one-cycle valid pulse follow an accepted read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    d_out_r    <= '0;
                    rd_valid_r <= 1'b0;
                end else begin
                    rd_valid_r <= rd_ok_s;
                    if (rd_ok_s) begin
                        d_out_r <= mem_r[rptr_r];
                    end
                end
            end

            assign bus.d_out    = d_out_r;
            assign bus.rd_valid = rd_valid_r;
        end
    endgenerate

    assign bus.wr_ack       = wr_ack_r;
    assign bus.full         = full_r;
    assign bus.empty        = empty_r;
    assign bus.almost_full  = almost_full_r;
    assign bus.almost_empty = almost_empty_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;
    assign bus.count        = count_r;

endmodule
